// File: rtl/ins_fetch_if.sv
// Instruction fetch buses: show-ahead stream FIFO on one side, layer FSM control on the other.
// master = fetch unit, slave = FIFO/layer side.
interface ins_fetch_if #(
  parameter int TBITS = 64
);
  logic [TBITS-1:0] isif_data_dout;
  logic             isif_last_dout;
  logic             isif_empty_n;
  logic             isif_read;
  logic             busy;
  logic             start;
  logic             auto;
  logic             man_reset;

  modport master (
    input  isif_data_dout, isif_last_dout, isif_empty_n, busy,
    output isif_read, start, auto, man_reset
  );

  modport slave (
    output isif_data_dout, isif_last_dout, isif_empty_n, busy,
    input  isif_read, start, auto, man_reset
  );
endinterface

// File: rtl/ins_fetch.sv
// Pops instruction words from a stream FIFO, decodes the low opcode nibble and drives
// start / manual-reset pulses to the layer FSM, waiting on its busy handshake.
module ins_fetch #(
  parameter int TBITS  = 64,
  parameter int TO_CYC = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  ins_fetch_if.master   bus,
  output logic [15:0]   ins_cnt,
  output logic          err_illegal,
  output logic          err_timeout,
  output logic          done,
  output logic [2:0]    fetch_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    END       = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_START = 4'h1;
  localparam logic [3:0] OP_MRST  = 4'h2;
  localparam logic [3:0] OP_END   = 4'hF;
  localparam int         CW       = $clog2(TO_CYC + 1);

  state_t           state, nxt;
  logic [TBITS-1:0] ins_reg;
  logic             last_reg;
  logic [CW-1:0]    to_cnt;
  logic             start_q, auto_q, mrst_q;
  logic [3:0]       op;
  logic             illegal;
  logic             ack_expired;
  state_t           after_ins;

  assign op          = ins_reg[3:0];
  assign illegal     = !(op == OP_NOP || op == OP_START || op == OP_MRST || op == OP_END);
  assign ack_expired = (to_cnt >= CW'(TO_CYC));
  assign after_ins   = last_reg ? END : FETCH;

  // Only opcode and the auto flag are architectural; the rest of the word is payload we drop.
  logic unused_hi;
  assign unused_hi = ^ins_reg[TBITS-1:5];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (en) nxt = FETCH;
      FETCH: begin
        if (!en)                   nxt = IDLE;
        else if (bus.isif_empty_n) nxt = ISSUE;
      end
      ISSUE: begin
        case (op)
          OP_START: nxt = WAIT_ACK;
          OP_END:   nxt = END;
          default:  nxt = after_ins;
        endcase
      end
      // busy arriving in the final allowed cycle still counts as an acknowledge
      WAIT_ACK: begin
        if (bus.busy)        nxt = WAIT_DONE;
        else if (ack_expired) nxt = after_ins;
      end
      WAIT_DONE: if (!bus.busy) nxt = after_ins;
      END:       if (!en) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.isif_read = (state == FETCH) && bus.isif_empty_n && en;
    fetch_state   = state;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ins_reg     <= '0;
      last_reg    <= 1'b0;
      ins_cnt     <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      to_cnt      <= '0;
      start_q     <= 1'b0;
      auto_q      <= 1'b0;
      mrst_q      <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (state == IDLE && en) begin
        ins_cnt     <= '0;
        err_illegal <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (bus.isif_read) begin
        ins_reg  <= bus.isif_data_dout;
        last_reg <= bus.isif_last_dout;
      end
      start_q <= (state == ISSUE) && (op == OP_START);
      mrst_q  <= (state == ISSUE) && (op == OP_MRST);
      if (state == ISSUE) begin
        if (ins_cnt != 16'hFFFF) ins_cnt <= ins_cnt + 16'd1;
        if (op == OP_START)      auto_q  <= ins_reg[4];
        if (illegal)             err_illegal <= 1'b1;
      end
      if (state == WAIT_ACK && !bus.busy && ack_expired) err_timeout <= 1'b1;
      // to_cnt holds the 1-based index of the current WAIT_ACK cycle
      if (state == ISSUE && op == OP_START) to_cnt <= CW'(1);
      else if (state == WAIT_ACK)           to_cnt <= to_cnt + CW'(1);
      else                                  to_cnt <= '0;
      done <= (nxt == END);
    end
  end

  assign bus.start     = start_q;
  assign bus.auto      = auto_q;
  assign bus.man_reset = mrst_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Randomised instruction programs against a per-program event model; a monitor pops
// expected start / man_reset / done events as the DUT produces them.
module tb_ins_fetch;
  localparam int TBITS  = 64;
  localparam int TO_CYC = 16;
  localparam int NEVER  = 999;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [15:0] ins_cnt;
  logic        err_illegal, err_timeout, done;
  logic [2:0]  fetch_state;

  ins_fetch_if #(.TBITS(TBITS)) bus();

  ins_fetch #(.TBITS(TBITS), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rstn(rstn), .en(en), .bus(bus),
    .ins_cnt(ins_cnt), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .done(done), .fetch_state(fetch_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 start, 1 man_reset, 2 done
    logic        auto_b;
    logic [15:0] cnt;
    logic        ei;
    logic        et;
  } ev_t;

  ev_t          exp_q[$];
  logic [64:0]  fifo[$];
  logic [64:0]  prog_w[$];
  int           total = 0;
  int           bad = 0;
  int           resp_delay = 0;
  int           resp_hold = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_fifo();
    bus.isif_empty_n = (fifo.size() != 0);
    if (fifo.size() != 0) begin
      bus.isif_data_dout = fifo[0][63:0];
      bus.isif_last_dout = fifo[0][64];
    end else begin
      bus.isif_data_dout = '0;
      bus.isif_last_dout = 1'b0;
    end
  endtask

  // FIFO: pop at the edge where the DUT asserted isif_read
  initial begin
    logic rd;
    drive_fifo();
    forever begin
      @(negedge clk);
      rd = bus.isif_read;
      @(posedge clk);
      #1;
      if (rd && fifo.size() != 0) void'(fifo.pop_front());
      drive_fifo();
    end
  end

  // Layer FSM stand-in: raises busy resp_delay cycles after start, holds it resp_hold cycles
  initial begin
    bus.busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && bus.start && resp_delay != NEVER) begin
        repeat (resp_delay) @(negedge clk);
        bus.busy = 1'b1;
        repeat (resp_hold) @(negedge clk);
        bus.busy = 1'b0;
      end
    end
  end

  task automatic expect_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      flag($sformatf("unexpected_event kind=%0d", kind));
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 64'(kind), 64'(e.kind));
    if (e.kind == 0 && kind == 0) chk("auto", 64'(bus.auto), 64'(e.auto_b));
    if (e.kind == 2 && kind == 2) begin
      chk("ins_cnt", 64'(ins_cnt), 64'(e.cnt));
      chk("err_illegal", 64'(err_illegal), 64'(e.ei));
      chk("err_timeout", 64'(err_timeout), 64'(e.et));
    end
  endtask

  initial begin
    logic prev_p = 1'b0;
    logic done_q = 1'b0;
    logic p;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_p = 1'b0;
        done_q = 1'b0;
      end else begin
        p = bus.start | bus.man_reset;
        if (p) chk("pulse_overlap", 64'(bus.start & bus.man_reset), 64'd0);
        if (p && prev_p) flag("pulse_back_to_back");
        if (bus.start)     expect_ev(0);
        if (bus.man_reset) expect_ev(1);
        if (done && !done_q) expect_ev(2);
        prev_p = p;
        done_q = done;
      end
    end
  end

  function automatic void add(input logic [63:0] d, input logic last);
    prog_w.push_back({last, d});
  endfunction

  // Expected event list for the program in prog_w, from the instruction-set rules
  task automatic model(input int dly);
    ev_t e;
    int  cnt = 0;
    logic ei = 1'b0, et = 1'b0, stop = 1'b0;
    for (int i = 0; i < prog_w.size() && !stop; i++) begin
      cnt = (cnt == 16'hFFFF) ? cnt : cnt + 1;
      e = '{kind: 0, auto_b: prog_w[i][4], cnt: 0, ei: 0, et: 0};
      case (prog_w[i][3:0])
        4'h0: ;
        4'h1: begin exp_q.push_back(e); if (dly == NEVER) et = 1'b1; end
        4'h2: begin e.kind = 1; exp_q.push_back(e); end
        4'hF: stop = 1'b1;
        default: ei = 1'b1;
      endcase
      if (prog_w[i][64]) stop = 1'b1;
    end
    e = '{kind: 2, auto_b: 1'b0, cnt: 16'(cnt), ei: ei, et: et};
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n = 0;
    while (fetch_state != s && n < 500) begin sync(); n++; end
    if (fetch_state != s) flag(nm);
  endtask

  task automatic wait_idle_busy();
    int n = 0;
    while (bus.busy && n < 200) begin sync(); n++; end
    if (bus.busy) flag("busy_release_timeout");
  endtask

  task automatic run_prog(input int dly, input int hold, input bit gap);
    int n = 0;
    model(dly);
    resp_delay = dly;
    resp_hold  = hold;
    sync();
    if (!gap) begin
      foreach (prog_w[i]) fifo.push_back(prog_w[i]);
      drive_fifo();
      en = 1'b1;
    end else begin
      en = 1'b1;
      wait_state(3'd1, "reach_fetch_timeout");
      for (int i = 0; i < 5; i++) begin
        sync();
        chk("empty_no_read", 64'(bus.isif_read), 64'd0);
        chk("empty_stay_fetch", 64'(fetch_state), 64'd1);
      end
      foreach (prog_w[i]) fifo.push_back(prog_w[i]);
      drive_fifo();
      #1 chk("pop_same_cycle", 64'(bus.isif_read), 64'd1);
    end
    while (!done && n < 1000) begin sync(); n++; end
    if (!done) flag("done_timeout");
    chk("end_state", 64'(fetch_state), 64'd5);
    sync();
    en = 1'b0;
    sync();
    sync();
    chk("back_to_idle", 64'(fetch_state), 64'd0);
    chk("done_cleared", 64'(done), 64'd0);
    chk("events_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    fifo.delete();
    drive_fifo();
    prog_w.delete();
    wait_idle_busy();
  endtask

  function automatic logic [63:0] rword(input logic [3:0] op);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[3:0] = op;
    return w;
  endfunction

  initial begin
    logic [3:0] op;
    int         len, sel, dly;
    drive_fifo();
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(fetch_state), 64'd0);
    chk("rst_outputs", 64'({bus.start, bus.auto, bus.man_reset, done, err_illegal, err_timeout, bus.isif_read}), 64'd0);
    chk("rst_ins_cnt", 64'(ins_cnt), 64'd0);
    sync();
    rstn = 1'b1;
    sync();

    // start with auto, then END
    add(64'h11, 1'b0); add(64'h0F, 1'b1);
    run_prog(2, 10, 1'b0);
    chk("auto_held", 64'(bus.auto), 64'd1);

    // man_reset, NOP, start auto=0
    add(64'h02, 1'b0); add(64'h00, 1'b0); add(64'h01, 1'b1);
    run_prog(3, 6, 1'b0);
    chk("auto_cleared", 64'(bus.auto), 64'd0);

    // illegal opcode, upper bits set to prove they are ignored
    add(64'hFFFF_0000_0000_00E7, 1'b0); add(64'h0F, 1'b0);
    run_prog(0, 1, 1'b0);

    // ack never comes
    add(64'h01, 1'b1);
    run_prog(NEVER, 1, 1'b0);

    // busy first seen in the last allowed WAIT_ACK cycle
    add(64'h01, 1'b1);
    run_prog(TO_CYC - 1, 3, 1'b0);

    // FIFO empty while fetching
    add(64'h0F, 1'b1);
    run_prog(0, 1, 1'b1);

    // reset during WAIT_DONE
    add(64'h11, 1'b1);
    model(0);
    resp_delay = 0;
    resp_hold  = 30;
    sync();
    foreach (prog_w[i]) fifo.push_back(prog_w[i]);
    drive_fifo();
    en = 1'b1;
    wait_state(3'd4, "reach_wait_done_timeout");
    rstn = 1'b0;
    #1;
    chk("mid_rst_state", 64'(fetch_state), 64'd0);
    chk("mid_rst_outputs", 64'({bus.start, bus.auto, bus.man_reset, done, err_illegal, err_timeout, bus.isif_read}), 64'd0);
    chk("mid_rst_ins_cnt", 64'(ins_cnt), 64'd0);
    exp_q.delete();
    prog_w.delete();
    fifo.delete();
    drive_fifo();
    en = 1'b0;
    sync();
    rstn = 1'b1;
    sync();
    wait_idle_busy();
    chk("post_rst_idle", 64'(fetch_state), 64'd0);
    add(64'h02, 1'b0); add(64'h00, 1'b1);
    run_prog(0, 1, 1'b0);

    // random programs
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1:    op = 4'h0;
          2, 3, 4: op = 4'h1;
          5, 6:    op = 4'h2;
          7:       op = 4'hF;
          default: op = 4'($urandom_range(3, 14));
        endcase
        add(rword(op), (i == len - 1));
      end
      sel = $urandom_range(0, 7);
      dly = (sel < 5) ? sel : (sel == 5) ? TO_CYC - 1 : NEVER;
      run_prog(dly, $urandom_range(1, 12), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end
endmodule
